// File: rtl/riscv_core_mul_pkg.sv
// riscv_core_mul_pkg
//   Shared types and helpers for the radix-4 Booth multiplier:
//   operation codes, FSM states, Booth digit encoding and per-op
//   signedness / result-half decode functions.
package riscv_core_mul_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   // Booth digit as {neg, one, two}
   typedef enum logic [2:0] {
      DIG_ZERO = 3'b000,
      DIG_P1   = 3'b010,
      DIG_P2   = 3'b001,
      DIG_M1   = 3'b110,
      DIG_M2   = 3'b101
   } booth_dig_e;

   function automatic logic op_rs1_signed(input mul_op_e op);
      return op != MULHU;
   endfunction

   function automatic logic op_rs2_signed(input mul_op_e op);
      return (op == MUL) || (op == MULH);
   endfunction

   function automatic logic op_high(input mul_op_e op);
      return op != MUL;
   endfunction

endpackage

// File: rtl/riscv_core_booth_r4_enc.sv
// riscv_core_booth_r4_enc
//   Radix-4 Booth recoder: maps the 3-bit multiplier window
//   {y[2i+1], y[2i], y[2i-1]} to a digit in {-2,-1,0,+1,+2}, expressed
//   as magnitude selects (one/two) plus a negate flag. Combinational.
// Ports
//   win_i  [2:0]  multiplier window
//   neg_o         subtract the selected multiple
//   one_o         select 1x multiplicand
//   two_o         select 2x multiplicand
module riscv_core_booth_r4_enc
   import riscv_core_mul_pkg::*;
(
   input  logic [2:0] win_i,
   output logic       neg_o,
   output logic       one_o,
   output logic       two_o
);

   booth_dig_e dig;

   always_comb begin
      dig = DIG_ZERO;
      unique case (win_i)
         3'b000, 3'b111: dig = DIG_ZERO;
         3'b001, 3'b010: dig = DIG_P1;
         3'b011:         dig = DIG_P2;
         3'b100:         dig = DIG_M2;
         3'b101, 3'b110: dig = DIG_M1;
         default:        dig = DIG_ZERO;
      endcase
   end

   assign {neg_o, one_o, two_o} = dig;

endmodule

// File: rtl/riscv_core_mul_r4.sv
// riscv_core_mul_r4
//   Sequential radix-4 Booth multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
//   Retires two multiplier bits per cycle; NDIG = (XLEN+2)/2 busy cycles.
// Ports
//   i_mul_clk, i_mul_rstn   clock, synchronous active-low reset
//   i_mul_flush             abort in-flight op (no result)
//   i_mul_valid/o_mul_ready request handshake (ready only in IDLE)
//   i_mul_op, i_mul_rs1/2   operation and operands, sampled at accept
//   o_mul_valid/i_mul_ready result handshake (valid held in DONE)
//   o_mul_product           full 2*XLEN product
//   o_mul_result            low half for MUL, high half otherwise
module riscv_core_mul_r4
   import riscv_core_mul_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic              i_mul_clk,
   input  logic              i_mul_rstn,
   input  logic              i_mul_flush,
   input  logic              i_mul_valid,
   output logic              o_mul_ready,
   input  logic [1:0]        i_mul_op,
   input  logic [XLEN-1:0]   i_mul_rs1,
   input  logic [XLEN-1:0]   i_mul_rs2,
   output logic              o_mul_valid,
   input  logic              i_mul_ready,
   output logic [2*XLEN-1:0] o_mul_product,
   output logic [XLEN-1:0]   o_mul_result
);

   localparam int unsigned NDIG = (XLEN + 2) / 2;
   localparam int unsigned YW   = XLEN + 2;   // extended operand width
   localparam int unsigned AW   = XLEN + 3;   // accumulator width
   localparam int unsigned CW   = $clog2(NDIG + 1);

   if (((XLEN % 2) != 0) || (XLEN < 8)) begin : g_bad_xlen
      $error("riscv_core_mul_r4: XLEN must be even and >= 8");
   end

   mul_state_e      state_q;
   mul_op_e         op_q;
   logic [CW-1:0]   cnt_q;
   logic [AW-1:0]   acc_q, acc_d;
   logic [YW-1:0]   y_q, y_d;
   logic            ym1_q, ym1_d;
   logic [YW-1:0]   m_q;

   logic            neg, one, two;
   logic [AW-1:0]   mx, mag, addend, sum;
   logic [YW-1:0]   rs1_ext, rs2_ext;
   logic [2*XLEN-1:0] product;
   mul_op_e         op_in;

   assign op_in   = mul_op_e'(i_mul_op);
   assign rs1_ext = {{2{op_rs1_signed(op_in) & i_mul_rs1[XLEN-1]}}, i_mul_rs1};
   assign rs2_ext = {{2{op_rs2_signed(op_in) & i_mul_rs2[XLEN-1]}}, i_mul_rs2};

   riscv_core_booth_r4_enc u_enc (
      .win_i ({y_q[1], y_q[0], ym1_q}),
      .neg_o (neg),
      .one_o (one),
      .two_o (two)
   );

   // acc += d*M, then arithmetic shift of {acc, y, y[-1]} right by 2
   always_comb begin
      mx  = {m_q[YW-1], m_q};
      mag = '0;
      if (one)
         mag = mx;
      else if (two)
         mag = {mx[AW-2:0], 1'b0};
      addend = neg ? ~mag : mag;
      sum    = acc_q + addend + {{(AW-1){1'b0}}, neg};
      acc_d  = {{2{sum[AW-1]}}, sum[AW-1:2]};
      y_d    = {sum[1:0], y_q[YW-1:2]};
      ym1_d  = y_q[1];
   end

   always_ff @(posedge i_mul_clk) begin
      if (!i_mul_rstn) begin
         state_q <= IDLE;
         op_q    <= MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         ym1_q   <= 1'b0;
         m_q     <= '0;
      end else if (i_mul_flush) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_mul_valid) begin
                  op_q    <= op_in;
                  m_q     <= rs1_ext;
                  y_q     <= rs2_ext;
                  ym1_q   <= 1'b0;
                  acc_q   <= '0;
                  cnt_q   <= CW'(NDIG);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               acc_q <= acc_d;
               y_q   <= y_d;
               ym1_q <= ym1_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_q <= DONE;
            end
            DONE: begin
               if (i_mul_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Low 2*XLEN bits of {acc, y}: y holds the low XLEN+2 product bits
   assign product       = {acc_q[XLEN-3:0], y_q};
   assign o_mul_product = product;
   assign o_mul_result  = op_high(op_q) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
   assign o_mul_ready   = (state_q == IDLE);
   assign o_mul_valid   = (state_q == DONE);

endmodule

// File: tb/tb_riscv_core_mul_r4.sv
module tb_riscv_core_mul_r4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn, flush, valid, rdy_in;
   logic [1:0]   op;
   logic [63:0]  rs1, rs2;
   logic         mready, mvalid;
   logic [127:0] prod;
   logic [63:0]  res;

   logic         valid8;
   logic [1:0]   op8;
   logic [7:0]   a8, b8;
   logic         mready8, mvalid8;
   logic [15:0]  prod8;
   logic [7:0]   res8;

   int ncmp = 0;
   int nmis = 0;

   riscv_core_mul_r4 #(.XLEN(64)) dut (
      .i_mul_clk     (clk),
      .i_mul_rstn    (rstn),
      .i_mul_flush   (flush),
      .i_mul_valid   (valid),
      .o_mul_ready   (mready),
      .i_mul_op      (op),
      .i_mul_rs1     (rs1),
      .i_mul_rs2     (rs2),
      .o_mul_valid   (mvalid),
      .i_mul_ready   (rdy_in),
      .o_mul_product (prod),
      .o_mul_result  (res)
   );

   riscv_core_mul_r4 #(.XLEN(8)) dut8 (
      .i_mul_clk     (clk),
      .i_mul_rstn    (rstn),
      .i_mul_flush   (1'b0),
      .i_mul_valid   (valid8),
      .o_mul_ready   (mready8),
      .i_mul_op      (op8),
      .i_mul_rs1     (a8),
      .i_mul_rs2     (b8),
      .o_mul_valid   (mvalid8),
      .i_mul_ready   (rdy_in),
      .o_mul_product (prod8),
      .o_mul_result  (res8)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Full handshake at XLEN=64 with i_mul_ready held high
   task automatic run64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input string tag);
      int n;
      logic [63:0] exp_res;
      exp_res = (o == 2'd0) ? exp[63:0] : exp[127:64];
      op = o; rs1 = a; rs2 = b; valid = 1'b1;
      chk({tag, "_rdy"}, 128'(mready), 128'd1);
      tick;
      valid = 1'b0;
      rs1 = ~a; rs2 = ~b; op = ~o;   // must not disturb the op in flight
      n = 0;
      while (!mvalid && n < 200) begin
         tick;
         n++;
      end
      chk({tag, "_lat"}, 128'(n), 128'd33);
      chk({tag, "_prod"}, prod, exp);
      chk({tag, "_res"}, 128'(res), 128'(exp_res));
      tick;
      chk({tag, "_idle"}, 128'({mready, mvalid}), 128'b10);
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string tag);
      int n;
      logic [7:0] exp_res;
      exp_res = (o == 2'd0) ? exp[7:0] : exp[15:8];
      op8 = o; a8 = a; b8 = b; valid8 = 1'b1;
      tick;
      valid8 = 1'b0;
      n = 0;
      while (!mvalid8 && n < 50) begin
         tick;
         n++;
      end
      chk({tag, "_lat"}, 128'(n), 128'd5);
      chk({tag, "_prod"}, 128'(prod8), 128'(exp));
      chk({tag, "_res"}, 128'(res8), 128'(exp_res));
      tick;
   endtask

   initial begin
      int n;
      logic seen;
      rstn = 1'b0; flush = 1'b0; valid = 1'b0; rdy_in = 1'b1;
      op = 2'd0; rs1 = '0; rs2 = '0;
      valid8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
      tick;
      tick;
      chk("rst_ready", 128'(mready), 128'd1);
      chk("rst_valid", 128'(mvalid), 128'd0);
      chk("rst_prod", prod, 128'd0);
      chk("rst_res", 128'(res), 128'd0);
      chk("rst8_state", 128'({mready8, mvalid8, prod8}), {110'd0, 2'b10, 16'h0000});
      rstn = 1'b1;
      tick;

      // Directed vectors, XLEN=64
      run64(2'd0, 64'hFFFFFFFFFFFFFFFD, 64'h5, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF1, "mul_m3x5");
      run64(2'd1, 64'h8000000000000000, 64'h8000000000000000,
            128'h40000000000000000000000000000000, "mulh_min2");
      run64(2'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
            128'hFFFFFFFFFFFFFFFE0000000000000001, "mulhu_ones");
      run64(2'd2, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
            128'hFFFFFFFFFFFFFFFF0000000000000001, "mulhsu_ones");
      run64(2'd1, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF,
            128'h3FFFFFFFFFFFFFFF0000000000000001, "mulh_max2");
      run64(2'd0, 64'h7, 64'hFFFFFFFFFFFFFFFE, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF2, "mul_7xm2");
      run64(2'd3, 64'h8000000000000000, 64'h2, 128'h00000000000000010000000000000000, "mulhu_2p64");
      run64(2'd2, 64'h2, 64'hFFFFFFFFFFFFFFFF, 128'h0000000000000001FFFFFFFFFFFFFFFE, "mulhsu_2xmax");
      run64(2'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'h1, "mulh_m1xm1");
      run64(2'd0, 64'h0, 64'hDEADBEEFCAFEF00D, 128'h0, "mul_zero");

      // Backpressure; new requests during BUSY/DONE are ignored
      rdy_in = 1'b0;
      op = 2'd0; rs1 = 64'd6; rs2 = 64'd7; valid = 1'b1;
      tick;
      op = 2'd3; rs1 = 64'hFFFF; rs2 = 64'hFFFF;
      n = 0;
      while (!mvalid && n < 200) begin
         tick;
         n++;
      end
      chk("bp_lat", 128'(n), 128'd33);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("bp_valid", 128'(mvalid), 128'd1);
         chk("bp_ready", 128'(mready), 128'd0);
         chk("bp_res", 128'(res), 128'h2A);
      end
      valid = 1'b0;
      rdy_in = 1'b1;
      tick;
      chk("bp_release", 128'({mready, mvalid}), 128'b10);

      // Flush during the fifth BUSY cycle
      op = 2'd0; rs1 = 64'd9; rs2 = 64'd9; valid = 1'b1;
      tick;
      valid = 1'b0;
      tick; tick; tick; tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_state", 128'({mready, mvalid}), 128'b10);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         seen = seen | mvalid;
      end
      chk("flush_novalid", 128'(seen), 128'd0);

      // Flush in IDLE blocks acceptance
      valid = 1'b1; flush = 1'b1;
      tick;
      valid = 1'b0; flush = 1'b0;
      chk("flush_idle_noacc", 128'({mready, mvalid}), 128'b10);
      run64(2'd0, 64'd12345, 64'd1000, 128'd12345000, "after_flush");

      // Reset mid-BUSY
      op = 2'd1; rs1 = 64'd3; rs2 = 64'd3; valid = 1'b1;
      tick;
      valid = 1'b0;
      tick; tick; tick;
      rstn = 1'b0;
      tick;
      chk("rstbusy_state", 128'({mready, mvalid}), 128'b10);
      chk("rstbusy_prod", prod, 128'd0);
      rstn = 1'b1;
      tick;
      run64(2'd3, 64'hFFFFFFFFFFFFFFFF, 64'd2, 128'h0000000000000001FFFFFFFFFFFFFFFE, "after_rst");

      // XLEN=8 instance
      run8(2'd1, 8'h80, 8'h80, 16'h4000, "x8_mulh_min2");
      run8(2'd3, 8'hFF, 8'hFF, 16'hFE01, "x8_mulhu_ones");
      run8(2'd2, 8'hFF, 8'hFF, 16'hFF01, "x8_mulhsu_ones");
      run8(2'd0, 8'hFD, 8'h05, 16'hFFF1, "x8_mul_m3x5");
      run8(2'd1, 8'h7F, 8'h80, 16'hC080, "x8_mulh_maxmin");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
